pet_io_fabric: RTL and testbench

Parametrised I/O decode, strobe-timing, read-return and interrupt-aggregation fabric for the PET I/O page (0xE800–0xE8FF).
- It sits between the CPU bus and NSLOT peripheral cores (PIAs, VIA, CRTC, future add-ons).
- It generalises the fixed four-chip decode to N one-hot slots with per-slot enable.
- It adds an optional internal interrupt controller: per-slot mask, per-slot level/edge mode, and edge-pending latches readable and clearable by the CPU.

---
 rtl/pet_io_pkg.sv | 18 +
 rtl/pet_io_irqctl.sv | 51 +++++
 rtl/pet_io_fabric.sv | 134 +++++++++++++
 tb/tb_pet_io_fabric.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_io_pkg.sv
// Shared constants and types for the PET I/O page fabric.
// Covers the control register indices, pipeline states and default open-bus value.
package pet_io_pkg;

  localparam logic [1:0] IDX_STATUS = 2'd0;
  localparam logic [1:0] IDX_MASK   = 2'd1;
  localparam logic [1:0] IDX_MODE   = 2'd2;
  localparam logic [1:0] IDX_ACK    = 2'd3;

  localparam logic [7:0] OPEN_BUS_DEF = 8'hE8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STB  = 2'd1,
    CAP  = 2'd2
  } state_t;

endpackage

// File: rtl/pet_io_irqctl.sv
// Interrupt controller: MASK/MODE registers and per-slot pending logic.
// In edge mode a pending bit is a set-latch; ACK clears it, but a same-clk set wins.
module pet_io_irqctl
  import pet_io_pkg::*;
#(
  parameter int NSLOT = 4,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wr_mask,
  input  logic             i_wr_mode,
  input  logic             i_wr_ack,
  input  logic [DW-1:0]    i_wdata,
  input  logic [NSLOT-1:0] i_slot_irq,
  output logic [NSLOT-1:0] o_pending,
  output logic [DW-1:0]    o_mask,
  output logic [DW-1:0]    o_mode
);

  logic [DW-1:0]    r_mask, r_mode;
  logic [NSLOT-1:0] r_edge, r_irq_d;
  logic [DW-1:0]    w_mode_nxt;
  logic [NSLOT-1:0] w_rise, w_set, w_clr, w_ack;

  assign w_mode_nxt = i_wr_mode ? i_wdata : r_mode;
  assign w_rise     = i_slot_irq & ~r_irq_d;
  assign w_ack      = {NSLOT{i_wr_ack}} & i_wdata[NSLOT-1:0];
  // Leaving edge mode drops any latched edge for that slot.
  assign w_clr      = w_ack | (r_mode[NSLOT-1:0] & ~w_mode_nxt[NSLOT-1:0]);
  assign w_set      = w_mode_nxt[NSLOT-1:0] & w_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask  <= '1;
      r_mode  <= '0;
      r_edge  <= '0;
      r_irq_d <= '0;
    end else begin
      if (i_wr_mask) r_mask <= i_wdata;
      r_mode  <= w_mode_nxt;
      r_edge  <= (r_edge & ~w_clr) | w_set;
      r_irq_d <= i_slot_irq;
    end
  end

  assign o_pending = (r_mode[NSLOT-1:0] & r_edge) | (~r_mode[NSLOT-1:0] & i_slot_irq);
  assign o_mask    = r_mask;
  assign o_mode    = r_mode;

endmodule

// File: rtl/pet_io_fabric.sv
// PET I/O page fabric: one-hot slot decode, strobe/capture pipeline, wired-AND
// read return and interrupt aggregation with an optional control window.
module pet_io_fabric
  import pet_io_pkg::*;
#(
  parameter int       NSLOT    = 4,
  parameter int       AW       = 8,
  parameter int       DW       = 8,
  parameter int       SEL_LSB  = 4,
  parameter logic [DW-1:0] OPEN_BUS = DW'(OPEN_BUS_DEF),
  parameter bit       CTRL_EN  = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                cs,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       data_in,
  output logic [DW-1:0]       data_out,
  input  logic [NSLOT-1:0]    slot_en,
  output logic [NSLOT-1:0]    slot_strobe,
  input  logic [NSLOT*DW-1:0] slot_rdata,
  input  logic [NSLOT-1:0]    slot_irq,
  output logic                irq
);

  state_t           r_state, w_state_nxt;
  logic             w_accept, w_ctrl_sel, w_ctl_wr;
  logic [NSLOT-1:0] w_sel, r_sel, r_strobe;
  logic             r_csel, r_we, r_irq, w_irq_nxt;
  logic [1:0]       r_idx;
  logic [DW-1:0]    r_wdata, r_dout, w_rd, w_ctrl_rd;
  logic [NSLOT-1:0] w_pending;
  logic [DW-1:0]    w_mask, w_mode;
  logic             w_wr_mask, w_wr_mode, w_wr_ack;
  logic             w_unused;

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_dec
    assign w_sel[gi] = cs & slot_en[gi] & addr[SEL_LSB+gi];
  end

  assign w_ctrl_sel = CTRL_EN & cs & (addr[AW-1:SEL_LSB] == '0);
  // A ce landing in STB is dropped; CAP may overlap the next access.
  assign w_accept   = ce & (r_state != STB);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = STB;
      STB:     w_state_nxt = CAP;
      CAP:     w_state_nxt = w_accept ? STB : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_strobe <= '0;
      r_sel    <= '0;
      r_csel   <= 1'b0;
      r_we     <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_dout   <= OPEN_BUS;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_strobe <= w_accept ? w_sel : '0;
      if (w_accept) begin
        r_sel   <= w_sel;
        r_csel  <= w_ctrl_sel;
        r_we    <= we;
        r_idx   <= addr[1:0];
        r_wdata <= data_in;
      end
      if (r_state == CAP)
        r_dout <= ((|r_sel) | r_csel) ? w_rd : OPEN_BUS;
      r_irq <= w_irq_nxt;
    end
  end

  assign w_ctl_wr  = (r_state == STB) & r_csel & r_we;
  assign w_wr_mask = w_ctl_wr & (r_idx == IDX_MASK);
  assign w_wr_mode = w_ctl_wr & (r_idx == IDX_MODE);
  assign w_wr_ack  = w_ctl_wr & (r_idx == IDX_ACK);

  always_comb begin
    w_ctrl_rd = '0;
    case (r_idx)
      IDX_STATUS: w_ctrl_rd[NSLOT-1:0] = w_pending;
      IDX_MASK:   w_ctrl_rd = w_mask;
      IDX_MODE:   w_ctrl_rd = w_mode;
      default:    w_ctrl_rd = '0;
    endcase
  end

  // Wired-AND over every selected source; unselected terms are all-ones.
  always_comb begin
    w_rd = '1;
    for (int i = 0; i < NSLOT; i++)
      if (r_sel[i]) w_rd = w_rd & slot_rdata[i*DW +: DW];
    if (r_csel) w_rd = w_rd & w_ctrl_rd;
  end

  if (CTRL_EN) begin : g_ctl
    pet_io_irqctl #(.NSLOT(NSLOT), .DW(DW)) u_irqctl (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_mask (w_wr_mask),
      .i_wr_mode (w_wr_mode),
      .i_wr_ack  (w_wr_ack),
      .i_wdata   (r_wdata),
      .i_slot_irq(slot_irq),
      .o_pending (w_pending),
      .o_mask    (w_mask),
      .o_mode    (w_mode)
    );
    assign w_irq_nxt = |(w_pending & w_mask[NSLOT-1:0]);
  end else begin : g_noctl
    assign w_pending = '0;
    assign w_mask    = '1;
    assign w_mode    = '0;
    assign w_irq_nxt = |slot_irq;
  end

  assign w_unused = ^{addr, data_in, r_wdata, w_wr_mask, w_wr_mode, w_wr_ack, w_mode};

  assign slot_strobe = r_strobe;
  assign data_out    = r_dout;
  assign irq         = r_irq;

endmodule

// File: tb/tb_pet_io_fabric.sv
// Bench for pet_io_fabric: one instance without and one with the control window,
// a per-cycle event-driven reference model, and hand-computed literal pins.
module tb_pet_io_fabric;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce, cs, we;
  logic [7:0]  addr, data_in;
  logic [3:0]  slot_en, slot_irq;
  logic [31:0] slot_rdata;
  logic [7:0]  do0, do1;
  logic [3:0]  so0, so1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pet_io_fabric #(.NSLOT(4), .AW(8), .DW(8), .SEL_LSB(4), .OPEN_BUS(8'hE8), .CTRL_EN(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cs(cs), .we(we), .addr(addr),
    .data_in(data_in), .data_out(do0), .slot_en(slot_en), .slot_strobe(so0),
    .slot_rdata(slot_rdata), .slot_irq(slot_irq), .irq(irq0));

  pet_io_fabric #(.NSLOT(4), .AW(8), .DW(8), .SEL_LSB(4), .OPEN_BUS(8'hE8), .CTRL_EN(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cs(cs), .we(we), .addr(addr),
    .data_in(data_in), .data_out(do1), .slot_en(slot_en), .slot_strobe(so1),
    .slot_rdata(slot_rdata), .slot_irq(slot_irq), .irq(irq1));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    bit         is_cap;
    logic [3:0] sel;
    bit         ctl;
    logic [1:0] idx;
    logic [7:0] wd;
  } ev_t;

  ev_t        evq[$];
  int         cyc, last_acc;
  logic [3:0] e_stb0, e_stb1;
  logic [7:0] e_do0, e_do1;
  logic       e_irq0, e_irq1;
  logic [7:0] m_mask, m_mode;
  logic [3:0] m_edge, m_prev;

  task automatic model_reset();
    e_stb0 = 4'h0; e_stb1 = 4'h0;
    e_do0 = 8'hE8; e_do1 = 8'hE8;
    e_irq0 = 1'b0; e_irq1 = 1'b0;
    m_mask = 8'hFF; m_mode = 8'h00; m_edge = 4'h0; m_prev = 4'h0;
    evq.delete();
    last_acc = -10;
  endtask

  function automatic logic [7:0] rd_val(input bit withctl, input ev_t e, input logic [3:0] pend);
    logic [7:0] v;
    bit ctl;
    ctl = withctl && e.ctl;
    if (e.sel == 4'h0 && !ctl) return 8'hE8;
    v = 8'hFF;
    for (int i = 0; i < 4; i++)
      if (e.sel[i]) v = v & slot_rdata[i*8 +: 8];
    if (ctl) begin
      case (e.idx)
        2'd0: v = v & {4'h0, pend};
        2'd1: v = v & m_mask;
        2'd2: v = v & m_mode;
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  task automatic model_step();
    logic [3:0] pend, rise, clr, ack;
    logic [7:0] nmask, nmode;
    ev_t keep[$];
    ev_t e;
    pend   = (m_mode[3:0] & m_edge) | (~m_mode[3:0] & slot_irq);
    e_irq0 = |slot_irq;
    e_irq1 = |(pend & m_mask[3:0]);
    e_stb0 = 4'h0; e_stb1 = 4'h0;
    nmask = m_mask; nmode = m_mode; ack = 4'h0;
    foreach (evq[j]) begin
      if (evq[j].due == cyc) begin
        if (evq[j].is_cap) begin
          e_do0 = rd_val(1'b0, evq[j], pend);
          e_do1 = rd_val(1'b1, evq[j], pend);
        end else if (evq[j].ctl) begin
          case (evq[j].idx)
            2'd1: nmask = evq[j].wd;
            2'd2: nmode = evq[j].wd;
            2'd3: ack   = evq[j].wd[3:0];
            default: ;
          endcase
        end
      end else begin
        keep.push_back(evq[j]);
      end
    end
    evq  = keep;
    rise = slot_irq & ~m_prev;
    clr  = ack | (m_mode[3:0] & ~nmode[3:0]);
    m_edge = (m_edge & ~clr) | (nmode[3:0] & rise);
    m_prev = slot_irq; m_mask = nmask; m_mode = nmode;
    if (ce && (cyc - last_acc != 1)) begin
      e.sel    = cs ? (slot_en & addr[7:4]) : 4'h0;
      e.ctl    = cs && (addr[7:4] == 4'h0);
      e.idx    = addr[1:0];
      e.wd     = data_in;
      e.due    = cyc + 2;
      e.is_cap = 1'b1;
      evq.push_back(e);
      if (we) begin
        e.due = cyc + 1; e.is_cap = 1'b0;
        evq.push_back(e);
      end
      e_stb0 = e.sel; e_stb1 = e.sel;
      last_acc = cyc;
    end
  endtask

  initial begin
    model_reset();
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) model_reset();
      chk("m_strobe0", {4'h0, so0}, {4'h0, e_stb0});
      chk("m_strobe1", {4'h0, so1}, {4'h0, e_stb1});
      chk("m_dout0", do0, e_do0);
      chk("m_dout1", do1, e_do1);
      chk("m_irq0", {7'h0, irq0}, {7'h0, e_irq0});
      chk("m_irq1", {7'h0, irq1}, {7'h0, e_irq1});
      if (reset_n) model_step();
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] stb_a, stb_b;

  task tick();
    @(posedge clk);
    #2;
  endtask

  task access(input logic [7:0] a, input logic w, input logic [7:0] d);
    cs = 1'b1; addr = a; we = w; data_in = d; ce = 1'b1;
    tick();
    stb_a = so0;
    ce = 1'b0;
    tick();
    stb_b = so0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; cs = 1'b0; we = 1'b0;
    addr = 8'h00; data_in = 8'h00; slot_en = 4'hF; slot_irq = 4'h0;
    slot_rdata = 32'h44_33_22_5A;
    repeat (3) tick();
    chk("rst_dout0", do0, 8'hE8);
    chk("rst_dout1", do1, 8'hE8);
    chk("rst_irq0", {7'h0, irq0}, 8'h00);
    chk("rst_strobe0", {4'h0, so0}, 8'h00);
    reset_n = 1'b1;
    tick();

    access(8'h00, 1'b0, 8'h00);
    chk("open_bus0", do0, 8'hE8);
    chk("status_idle1", do1, 8'h00);

    access(8'h10, 1'b0, 8'h00);
    chk("single_stb", {4'h0, stb_a}, 8'h01);
    chk("single_stb_drop", {4'h0, stb_b}, 8'h00);
    chk("single_rd", do0, 8'h5A);

    slot_rdata = 32'h00_00_3C_F0;
    access(8'h30, 1'b0, 8'h00);
    chk("contention", do0, 8'h30);
    slot_en = 4'b1101;
    access(8'h30, 1'b0, 8'h00);
    chk("contention_dis", do0, 8'hF0);
    slot_en = 4'hF;

    // back-to-back at 2-clk spacing, then a ce held into STB
    slot_rdata = 32'h44_33_22_5A;
    cs = 1'b1; we = 1'b0; addr = 8'h10; ce = 1'b1;
    tick(); ce = 1'b0;
    tick(); addr = 8'h20; ce = 1'b1;
    tick(); chk("b2b_first", do0, 8'h5A); ce = 1'b0;
    tick(); tick();
    chk("b2b_second", do0, 8'h22);
    addr = 8'h40; ce = 1'b1;
    tick(); tick(); ce = 1'b0;
    tick(); tick();
    chk("ce_in_stb", do0, 8'h33);

    // edge-mode interrupt
    access(8'h02, 1'b1, 8'h0F);
    slot_irq = 4'b0100;
    tick();
    slot_irq = 4'h0;
    chk("edge_irq_lat1", {7'h0, irq1}, 8'h00);
    tick();
    chk("edge_irq_lat2", {7'h0, irq1}, 8'h01);
    access(8'h00, 1'b0, 8'h00);
    chk("edge_status", do1, 8'h04);
    access(8'h03, 1'b1, 8'h04);
    chk("edge_ack", {7'h0, irq1}, 8'h00);

    // edge arrives in the same clk as the ACK write
    cs = 1'b1; addr = 8'h03; we = 1'b1; data_in = 8'h04; ce = 1'b1;
    tick(); ce = 1'b0; slot_irq = 4'b0100;
    tick(); slot_irq = 4'h0;
    tick();
    access(8'h00, 1'b0, 8'h00);
    chk("set_wins", do1, 8'h04);
    chk("set_wins_irq", {7'h0, irq1}, 8'h01);
    access(8'h03, 1'b1, 8'h04);
    access(8'h02, 1'b1, 8'h00);
    access(8'h02, 1'b0, 8'h00);
    chk("mode_rd", do1, 8'h00);

    // level-mode masking
    slot_irq = 4'b0010;
    tick(); tick();
    chk("lvl_irq", {7'h0, irq1}, 8'h01);
    access(8'h01, 1'b1, 8'hFD);
    chk("mask_off", {7'h0, irq1}, 8'h00);
    chk("mask_off_noctl", {7'h0, irq0}, 8'h01);
    access(8'h01, 1'b1, 8'hFF);
    chk("mask_on", {7'h0, irq1}, 8'h01);
    slot_irq = 4'h0;
    tick();

    // reset in the middle of an access
    access(8'h01, 1'b1, 8'h55);
    access(8'h01, 1'b0, 8'h00);
    chk("mask_rd55", do1, 8'h55);
    cs = 1'b1; addr = 8'h10; we = 1'b0; ce = 1'b1;
    tick();
    chk("mid_stb", {4'h0, so0}, 8'h01);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_stb0", {4'h0, so0}, 8'h00);
    chk("mid_rst_stb1", {4'h0, so1}, 8'h00);
    ce = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("post_rst_dout0", do0, 8'hE8);
    chk("post_rst_dout1", do1, 8'hE8);
    access(8'h01, 1'b0, 8'h00);
    chk("post_rst_mask", do1, 8'hFF);
    chk("post_rst_open", do0, 8'hE8);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
